aes_sbox_arbiter: RTL and testbench
===================================

Name: aes_sbox_arbiter

Overview:
Arbitrates the single shared sbox substitution engine between two requesters: requester 0 is the encryption datapath (SubBytes, full 4x4 state) and requester 1 is the round-key expansion (SubWord, one column).
- Captures the granted requester's matrix and masks, drives the sbox, waits for its valid, then returns the registered result with a one-cycle done pulse.
- Sits between aes_en_core / key expansion and the sbox instance.

Parameters:
NO_ROWS, 4, rows of the state matrix
NO_COLS, 4, columns of the state matrix
TIMEOUT_CYCLES, 64, maximum BUSY cycles before abort (used only with the optional feature)

Ports:
aes_clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
req_i  input  2  per-requester request, bit0 = datapath, bit1 = key expansion
req_matrix_i  input  2x(8*NO_ROWS*NO_COLS)  per-requester packed matrix, byte [r][c] at bits 8*(NO_COLS*r+c) +: 8
req_row_mask_i  input  2x4  per-requester row mask
req_col_mask_i  input  2x4  per-requester column mask
gnt_o  output  2  one-cycle grant pulse, one-hot
done_o  output  2  one-cycle completion pulse, one-hot
err_o  output  2  one-cycle timeout pulse, coincident with done_o
result_o  output  8*NO_ROWS*NO_COLS  substituted matrix of the last completed access
sbox_en_o  output  1  sbox enable
sbox_matrix_o  output  8*NO_ROWS*NO_COLS  registered matrix to sbox
sbox_row_mask_o  output  4  registered row mask to sbox
sbox_col_mask_o  output  4  registered column mask to sbox
sbox_valid_i  input  1  sbox output valid
sbox_result_i  input  8*NO_ROWS*NO_COLS  sbox output matrix

Behaviour:
- Reset (async):
  - outputs: gnt_o, done_o, err_o, result_o, sbox_en_o, sbox_matrix_o and both masks = 0.
  - internal: state = IDLE, owner = 0, last_served = 1 (so the datapath wins the first tie), timer = 0.
  - Reset mid-access drops sbox_en_o immediately and discards the access; no done_o is issued.
- FSM states: IDLE, BUSY, BYPASS, DRAIN.
- IDLE:
  - Only one requester active: grant it.
  - Both active: grant the requester != last_served (round-robin).
  - On grant: owner <= winner, last_served <= winner, capture winner's matrix and masks into the sbox_* registers, gnt_o[winner] = 1 for one cycle.
  - Next state: BYPASS if either captured mask == 0, else BUSY with sbox_en_o = 1.
- BUSY:
  - sbox_en_o held 1, timer increments.
  - sbox_valid_i sampled 1: result_o <= sbox_result_i, sbox_en_o <= 0, done_o[owner] = 1 next cycle, go to DRAIN.
  - Owner drops req_i while BUSY (abort): sbox_en_o <= 0, no done_o, result_o unchanged, go to DRAIN.
  - Abort and valid in the same cycle: valid wins, so done is issued.
- BYPASS: result_o <= captured matrix unchanged, done_o[owner] = 1, go to DRAIN. The sbox is not enabled.
- DRAIN:
  - Minimum 1 cycle; remain while sbox_valid_i == 1, then go to IDLE.
  - Requests are not sampled in DRAIN, so the owner must deassert req_i in the cycle done_o is seen.
  - A req_i still high when IDLE is re-entered is a new request.
- Latency: req sampled at edge E0 -> gnt_o and sbox_en_o high after E0. With a combinational sbox valid, done_o is high after E1 (2 edges). Bypass: done_o after E1.
- result_o is held stable from done_o until the next completion of either requester. Requesters copy it on done_o.
- The other requester may hold req_i indefinitely; it is granted at the next IDLE, guaranteeing at most one access of waiting.
- gnt_o, done_o and err_o are never asserted for both requesters in one cycle.

Optional Feature:
Macro AES_SBOX_ARB_TIMEOUT_EN.
- Defined: in BUSY, if the timer reaches TIMEOUT_CYCLES-1 without sbox_valid_i:
  - sbox_en_o <= 0 and result_o <= 0;
  - done_o[owner] and err_o[owner] pulse together;
  - go to DRAIN; timer clears on every grant.
- Not defined: no timer logic, err_o tied to 0, BUSY waits for sbox_valid_i indefinitely.

Test Plan:
1. Datapath req, masks F/F, matrix all 0x00, sbox valid 1 cycle after en -> gnt_o=01, done_o=01 two edges after req, result_o all 0x63, sbox_en_o low after done.
2. Both req same cycle after reset -> datapath granted first. Keep both asserted -> key expansion granted next. Then datapath again (alternation 01, 10, 01).
3. Key-expansion req, col mask 0x1, column 0 = 0x19,0x53,0x00,0x01 -> result column 0 = 0xD4,0xED,0x63,0x7C; done_o=10.
4. Row mask 0x0 with matrix 0xA5 bytes -> sbox_en_o never rises, done_o after 1 edge, result_o all 0xA5.
5. Owner drops req in BUSY before valid -> sbox_en_o low next cycle, no done_o, result_o unchanged. resetn low mid-BUSY -> all outputs 0 asynchronously.
6. AES_SBOX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, sbox_valid_i stuck 0 -> done_o and err_o pulse together 8 cycles after grant, result_o = 0. Without the macro -> BUSY persists, err_o = 0.

Source files
------------

// File: rtl/aes_sbox_arbiter_if.sv
// aes_sbox_arbiter_if: requester and sbox signal bundle around the sbox arbiter
interface aes_sbox_arbiter_if #(
  parameter int NO_ROWS = 4,
  parameter int NO_COLS = 4
);
  localparam int W = 8*NO_ROWS*NO_COLS;
  logic [1:0]          req_i;
  logic [1:0][W-1:0]   req_matrix_i;
  logic [1:0][3:0]     req_row_mask_i;
  logic [1:0][3:0]     req_col_mask_i;
  logic [1:0]          gnt_o;
  logic [1:0]          done_o;
  logic [1:0]          err_o;
  logic [W-1:0]        result_o;
  logic                sbox_en_o;
  logic [W-1:0]        sbox_matrix_o;
  logic [3:0]          sbox_row_mask_o;
  logic [3:0]          sbox_col_mask_o;
  logic                sbox_valid_i;
  logic [W-1:0]        sbox_result_i;
  modport slave (
    input  req_i, req_matrix_i, req_row_mask_i, req_col_mask_i, sbox_valid_i, sbox_result_i,
    output gnt_o, done_o, err_o, result_o, sbox_en_o, sbox_matrix_o, sbox_row_mask_o, sbox_col_mask_o
  );
  modport master (
    output req_i, req_matrix_i, req_row_mask_i, req_col_mask_i, sbox_valid_i, sbox_result_i,
    input  gnt_o, done_o, err_o, result_o, sbox_en_o, sbox_matrix_o, sbox_row_mask_o, sbox_col_mask_o
  );
endinterface

// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter: round-robin share of one sbox between datapath (0) and key expansion (1); optional BUSY timeout via AES_SBOX_ARB_TIMEOUT_EN
module aes_sbox_arbiter #(
  parameter int NO_ROWS        = 4,
  parameter int NO_COLS        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               aes_clk,
  input logic               resetn,
  aes_sbox_arbiter_if.slave bus
);
  localparam int W = 8*NO_ROWS*NO_COLS;
  typedef enum logic [1:0] {IDLE, BUSY, BYPASS, DRAIN} state_t;
  state_t         r_state;
  logic           r_owner;
  logic           r_last;
  logic [1:0]     r_gnt;
  logic [1:0]     r_done;
  logic [W-1:0]   r_result;
  logic [W-1:0]   r_matrix;
  logic [3:0]     r_row_mask;
  logic [3:0]     r_col_mask;
  logic           r_en;
  logic           w_win;
  logic [1:0]     w_owner_oh;
  logic           w_zero_mask;
  logic           w_grant;
  logic           w_timeout;
  assign w_win       = &bus.req_i ? ~r_last : bus.req_i[1];
  assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;
  assign w_zero_mask = ~|bus.req_row_mask_i[w_win] | ~|bus.req_col_mask_i[w_win];
  assign w_grant     = (r_state == IDLE) & |bus.req_i;
`ifdef AES_SBOX_ARB_TIMEOUT_EN
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0]  r_timer;
  logic [1:0]     r_err;
  assign w_timeout  = (r_state == BUSY) & ~bus.sbox_valid_i & (r_timer == TW'(TIMEOUT_CYCLES-1));
  assign bus.err_o  = r_err;
  // BUSY watchdog: cleared on each grant, err pulses alongside the timeout done
  always_ff @(posedge aes_clk or negedge resetn)
    if (!resetn) begin
      r_timer <= '0;
      r_err   <= '0;
    end else begin
      r_timer <= w_grant ? '0 : (r_state == BUSY) ? r_timer + 1'b1 : r_timer;
      r_err   <= w_timeout ? w_owner_oh : 2'b00;
    end
`else
  assign w_timeout = 1'b0;
  assign bus.err_o = 2'b00;
`endif
  // arbitration FSM with all sbox and requester outputs registered
  always_ff @(posedge aes_clk or negedge resetn)
    if (!resetn) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_gnt      <= '0;
      r_done     <= '0;
      r_result   <= '0;
      r_matrix   <= '0;
      r_row_mask <= '0;
      r_col_mask <= '0;
      r_en       <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        IDLE:
          if (|bus.req_i) begin
            r_owner    <= w_win;
            r_last     <= w_win;
            r_gnt      <= w_win ? 2'b10 : 2'b01;
            r_matrix   <= bus.req_matrix_i[w_win];
            r_row_mask <= bus.req_row_mask_i[w_win];
            r_col_mask <= bus.req_col_mask_i[w_win];
            r_en       <= ~w_zero_mask;
            r_state    <= w_zero_mask ? BYPASS : BUSY;
          end
        BUSY:
          if (bus.sbox_valid_i) begin
            r_result <= bus.sbox_result_i;
            r_done   <= w_owner_oh;
            r_en     <= 1'b0;
            r_state  <= DRAIN;
          end else if (w_timeout) begin
            r_result <= '0;
            r_done   <= w_owner_oh;
            r_en     <= 1'b0;
            r_state  <= DRAIN;
          end else if (!bus.req_i[r_owner]) begin
            r_en    <= 1'b0;
            r_state <= DRAIN;
          end
        BYPASS: begin
          r_result <= r_matrix;
          r_done   <= w_owner_oh;
          r_state  <= DRAIN;
        end
        default:
          if (!bus.sbox_valid_i) r_state <= IDLE;
      endcase
    end
  assign bus.gnt_o           = r_gnt;
  assign bus.done_o          = r_done;
  assign bus.result_o        = r_result;
  assign bus.sbox_en_o       = r_en;
  assign bus.sbox_matrix_o   = r_matrix;
  assign bus.sbox_row_mask_o = r_row_mask;
  assign bus.sbox_col_mask_o = r_col_mask;
endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// tb_aes_sbox_arbiter: directed tests of the sbox arbiter against a behavioural sbox
module tb_aes_sbox_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sb_hold = 1'b0;
  int errors = 0;
  int checks = 0;
  aes_sbox_arbiter_if #(.NO_ROWS(4), .NO_COLS(4)) bus();
  aes_sbox_arbiter #(.NO_ROWS(4), .NO_COLS(4), .TIMEOUT_CYCLES(8)) dut (.aes_clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] sub(input logic [7:0] b);
    case (b)
      8'h00: sub = 8'h63;
      8'h01: sub = 8'h7c;
      8'h19: sub = 8'hd4;
      8'h53: sub = 8'hed;
      8'h11: sub = 8'h82;
      default: sub = ~b;
    endcase
  endfunction
  function automatic logic [127:0] sbox_model(input logic [127:0] m, input logic [3:0] rm, input logic [3:0] cm);
    logic [127:0] o;
    o = m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (rm[r] & cm[c]) o[8*(4*r+c) +: 8] = sub(m[8*(4*r+c) +: 8]);
    return o;
  endfunction
  always_comb begin
    bus.sbox_valid_i  = bus.sbox_en_o & ~sb_hold;
    bus.sbox_result_i = sbox_model(bus.sbox_matrix_o, bus.sbox_row_mask_o, bus.sbox_col_mask_o);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    bus.req_i = 2'b00;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask
  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 10 && g == 2'b00; i++) begin
      step();
      g = bus.gnt_o;
    end
  endtask
  task automatic test_reset();
    bus.req_i = 2'b00;
    bus.req_matrix_i = '0;
    bus.req_row_mask_i = '0;
    bus.req_col_mask_i = '0;
    #2;
    checks++; if (bus.gnt_o !== 2'b00 || bus.done_o !== 2'b00 || bus.err_o !== 2'b00) begin errors++; $display("FAIL reset_pulses: gnt=%b done=%b err=%b want 00", bus.gnt_o, bus.done_o, bus.err_o); end
    checks++; if (bus.result_o !== 128'h0 || bus.sbox_matrix_o !== 128'h0) begin errors++; $display("FAIL reset_data: result=%h matrix=%h want 0", bus.result_o, bus.sbox_matrix_o); end
    checks++; if (bus.sbox_en_o !== 1'b0 || bus.sbox_row_mask_o !== 4'h0 || bus.sbox_col_mask_o !== 4'h0) begin errors++; $display("FAIL reset_sbox: en=%b rm=%h cm=%h want 0", bus.sbox_en_o, bus.sbox_row_mask_o, bus.sbox_col_mask_o); end
    @(negedge clk);
    resetn = 1'b1;
  endtask
  task automatic test_single();
    bus.req_matrix_i[0] = '0;
    bus.req_row_mask_i[0] = 4'hf;
    bus.req_col_mask_i[0] = 4'hf;
    bus.req_i = 2'b01;
    step();
    checks++; if (bus.gnt_o !== 2'b01 || bus.sbox_en_o !== 1'b1) begin errors++; $display("FAIL single_gnt: gnt=%b en=%b want 01/1", bus.gnt_o, bus.sbox_en_o); end
    step();
    bus.req_i = 2'b00;
    checks++; if (bus.done_o !== 2'b01 || bus.gnt_o !== 2'b00) begin errors++; $display("FAIL single_done: done=%b gnt=%b want 01/00", bus.done_o, bus.gnt_o); end
    checks++; if (bus.result_o !== {16{8'h63}}) begin errors++; $display("FAIL single_result: got %h want %h", bus.result_o, {16{8'h63}}); end
    checks++; if (bus.sbox_en_o !== 1'b0) begin errors++; $display("FAIL single_en_drop: got %b want 0", bus.sbox_en_o); end
    step();
    checks++; if (bus.done_o !== 2'b00) begin errors++; $display("FAIL single_done_pulse: got %b want 00", bus.done_o); end
    step();
  endtask
  task automatic test_round_robin();
    logic [1:0] g;
    logic [1:0] exp_g;
    apply_reset();
    bus.req_matrix_i = '0;
    bus.req_row_mask_i = {4'hf, 4'hf};
    bus.req_col_mask_i = {4'hf, 4'hf};
    bus.req_i = 2'b11;
    exp_g = 2'b01;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(g);
      checks++; if (g !== exp_g) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", k, g, exp_g); end
      step();
      checks++; if (bus.done_o !== exp_g) begin errors++; $display("FAIL rr_done%0d: got %b want %b", k, bus.done_o, exp_g); end
      exp_g = ~exp_g;
    end
    bus.req_i = 2'b00;
    step();
    step();
  endtask
  task automatic test_key_column();
    logic [127:0] m;
    logic [127:0] e;
    m = '0;
    m[7:0] = 8'h19; m[39:32] = 8'h53; m[71:64] = 8'h00; m[103:96] = 8'h01;
    e = '0;
    e[7:0] = 8'hd4; e[39:32] = 8'hed; e[71:64] = 8'h63; e[103:96] = 8'h7c;
    bus.req_matrix_i[1] = m;
    bus.req_row_mask_i[1] = 4'hf;
    bus.req_col_mask_i[1] = 4'h1;
    bus.req_i = 2'b10;
    step();
    checks++; if (bus.gnt_o !== 2'b10 || bus.sbox_col_mask_o !== 4'h1) begin errors++; $display("FAIL key_gnt: gnt=%b cm=%h want 10/1", bus.gnt_o, bus.sbox_col_mask_o); end
    step();
    bus.req_i = 2'b00;
    checks++; if (bus.done_o !== 2'b10) begin errors++; $display("FAIL key_done: got %b want 10", bus.done_o); end
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL key_result: got %h want %h", bus.result_o, e); end
    step();
    step();
  endtask
  task automatic test_bypass();
    bus.req_matrix_i[0] = {16{8'ha5}};
    bus.req_row_mask_i[0] = 4'h0;
    bus.req_col_mask_i[0] = 4'hf;
    bus.req_i = 2'b01;
    step();
    checks++; if (bus.gnt_o !== 2'b01 || bus.sbox_en_o !== 1'b0) begin errors++; $display("FAIL bypass_gnt: gnt=%b en=%b want 01/0", bus.gnt_o, bus.sbox_en_o); end
    step();
    bus.req_i = 2'b00;
    checks++; if (bus.done_o !== 2'b01 || bus.sbox_en_o !== 1'b0) begin errors++; $display("FAIL bypass_done: done=%b en=%b want 01/0", bus.done_o, bus.sbox_en_o); end
    checks++; if (bus.result_o !== {16{8'ha5}}) begin errors++; $display("FAIL bypass_result: got %h want %h", bus.result_o, {16{8'ha5}}); end
    step();
    step();
  endtask
  task automatic test_abort();
    sb_hold = 1'b1;
    bus.req_matrix_i[0] = '0;
    bus.req_row_mask_i[0] = 4'hf;
    bus.req_col_mask_i[0] = 4'hf;
    bus.req_i = 2'b01;
    step();
    checks++; if (bus.sbox_en_o !== 1'b1) begin errors++; $display("FAIL abort_en_rise: got %b want 1", bus.sbox_en_o); end
    bus.req_i = 2'b00;
    step();
    checks++; if (bus.sbox_en_o !== 1'b0 || bus.done_o !== 2'b00) begin errors++; $display("FAIL abort_drop: en=%b done=%b want 0/00", bus.sbox_en_o, bus.done_o); end
    checks++; if (bus.result_o !== {16{8'ha5}}) begin errors++; $display("FAIL abort_result: got %h want %h", bus.result_o, {16{8'ha5}}); end
    step();
    checks++; if (bus.done_o !== 2'b00) begin errors++; $display("FAIL abort_no_done: got %b want 00", bus.done_o); end
    step();
    bus.req_matrix_i[1] = {16{8'h11}};
    bus.req_row_mask_i[1] = 4'hf;
    bus.req_col_mask_i[1] = 4'hf;
    bus.req_i = 2'b10;
    step();
    step();
    checks++; if (bus.sbox_en_o !== 1'b1) begin errors++; $display("FAIL rst_busy_en: got %b want 1", bus.sbox_en_o); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (bus.sbox_en_o !== 1'b0 || bus.result_o !== 128'h0 || bus.sbox_matrix_o !== 128'h0) begin errors++; $display("FAIL rst_async: en=%b result=%h matrix=%h want 0", bus.sbox_en_o, bus.result_o, bus.sbox_matrix_o); end
    checks++; if (bus.sbox_row_mask_o !== 4'h0 || bus.sbox_col_mask_o !== 4'h0 || bus.gnt_o !== 2'b00 || bus.done_o !== 2'b00) begin errors++; $display("FAIL rst_async_ctl: rm=%h cm=%h gnt=%b done=%b want 0", bus.sbox_row_mask_o, bus.sbox_col_mask_o, bus.gnt_o, bus.done_o); end
    bus.req_i = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
    step();
    checks++; if (bus.done_o !== 2'b00) begin errors++; $display("FAIL rst_no_done: got %b want 00", bus.done_o); end
    sb_hold = 1'b0;
  endtask
  task automatic test_timeout();
    bus.req_matrix_i[0] = {16{8'ha5}};
    bus.req_row_mask_i[0] = 4'h0;
    bus.req_col_mask_i[0] = 4'hf;
    bus.req_i = 2'b01;
    step();
    step();
    bus.req_i = 2'b00;
    step();
    step();
    sb_hold = 1'b1;
    bus.req_matrix_i[0] = {16{8'h11}};
    bus.req_row_mask_i[0] = 4'hf;
    bus.req_i = 2'b01;
    step();
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL to_gnt: got %b want 01", bus.gnt_o); end
    for (int i = 1; i < 8; i++) begin
      step();
      checks++; if (bus.done_o !== 2'b00 || bus.err_o !== 2'b00) begin errors++; $display("FAIL to_early%0d: done=%b err=%b want 00", i, bus.done_o, bus.err_o); end
    end
    step();
`ifdef AES_SBOX_ARB_TIMEOUT_EN
    checks++; if (bus.done_o !== 2'b01 || bus.err_o !== 2'b01) begin errors++; $display("FAIL to_fire: done=%b err=%b want 01/01", bus.done_o, bus.err_o); end
    checks++; if (bus.result_o !== 128'h0 || bus.sbox_en_o !== 1'b0) begin errors++; $display("FAIL to_result: result=%h en=%b want 0/0", bus.result_o, bus.sbox_en_o); end
    bus.req_i = 2'b00;
`else
    checks++; if (bus.done_o !== 2'b00 || bus.err_o !== 2'b00 || bus.sbox_en_o !== 1'b1) begin errors++; $display("FAIL to_persist: done=%b err=%b en=%b want 00/00/1", bus.done_o, bus.err_o, bus.sbox_en_o); end
    checks++; if (bus.result_o !== {16{8'ha5}}) begin errors++; $display("FAIL to_result: got %h want %h", bus.result_o, {16{8'ha5}}); end
    bus.req_i = 2'b00;
    step();
    checks++; if (bus.sbox_en_o !== 1'b0) begin errors++; $display("FAIL to_abort: got %b want 0", bus.sbox_en_o); end
`endif
    sb_hold = 1'b0;
    step();
    step();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_key_column();
    test_bypass();
    test_abort();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
